// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared FSM state and owner encodings for the memory port arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef logic arb_owner_t;

  localparam arb_owner_t OWN_FETCH = 1'b0;
  localparam arb_owner_t OWN_DATA  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_starve_counter.sv
// ---------------------------------------------------------------------------
// arb_starve_counter
// Saturating count of data grants taken while fetch was waiting.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb_starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int            CW    = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX_C)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max_o = (count_q == MAX_C);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Single-outstanding arbiter sharing one memory port between fetch and data.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_req_i,
  input  logic [AW-1:0]   fetch_addr_i,
  input  logic            fetch_kill_i,
  output logic            fetch_rvalid_o,
  output logic [DW-1:0]   fetch_rdata_o,
  output logic            fetch_stall_o,
  input  logic            data_req_i,
  input  logic            data_we_i,
  input  logic [DW/8-1:0] data_be_i,
  input  logic [AW-1:0]   data_addr_i,
  input  logic [DW-1:0]   data_wdata_i,
  output logic            data_rvalid_o,
  output logic [DW-1:0]   data_rdata_o,
  output logic            data_stall_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [DW-1:0]   mem_rdata_i
);

  arb_state_e      state_q,  state_d;
  arb_owner_t      owner_q,  owner_d;
  logic            killed_q, killed_d;
  logic [AW-1:0]   addr_q,   addr_d;
  logic            we_q,     we_d;
  logic [DW/8-1:0] be_q,     be_d;
  logic [DW-1:0]   wdata_q,  wdata_d;

  logic fetch_ok;
  logic accept_fetch;
  logic accept_data;
  logic starve_at_max;
  logic starve_clr;
  logic kill_owned;

  // A redirect in the same cycle removes fetch from arbitration entirely.
  assign fetch_ok   = fetch_req_i & ~fetch_kill_i;
  assign kill_owned = fetch_kill_i & (owner_q == OWN_FETCH);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    killed_d     = killed_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    accept_fetch = 1'b0;
    accept_data  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        killed_d = 1'b0;
        if (data_req_i && !(fetch_ok && starve_at_max)) begin
          accept_data = 1'b1;
          state_d     = ST_REQ;
          owner_d     = OWN_DATA;
          addr_d      = data_addr_i;
          we_d        = data_we_i;
          be_d        = data_be_i;
          wdata_d     = data_wdata_i;
        end else if (fetch_ok) begin
          accept_fetch = 1'b1;
          state_d      = ST_REQ;
          owner_d      = OWN_FETCH;
          addr_d       = fetch_addr_i;
          we_d         = 1'b0;
          be_d         = '1;
          wdata_d      = '0;
        end
      end
      ST_REQ: begin
        if (kill_owned) begin
          killed_d = 1'b1;
        end
        if (mem_gnt_i) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_rvalid_i) begin
          state_d  = ST_IDLE;
          killed_d = 1'b0;
        end else if (kill_owned) begin
          killed_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_FETCH;
      killed_q <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      killed_q <= killed_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

  assign starve_clr = accept_fetch | ((state_q == ST_IDLE) & ~fetch_req_i);

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc_i    (accept_data & fetch_req_i),
    .clr_i    (starve_clr),
    .at_max_o (starve_at_max)
  );

  assign mem_req_o   = (state_q == ST_REQ);
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  // A kill arriving with the response itself must also suppress it.
  assign fetch_rvalid_o = (state_q == ST_RESP) & (owner_q == OWN_FETCH) & mem_rvalid_i
                          & ~killed_q & ~fetch_kill_i;
  assign data_rvalid_o  = (state_q == ST_RESP) & (owner_q == OWN_DATA) & mem_rvalid_i;
  assign fetch_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign fetch_stall_o = fetch_req_i & ~fetch_rvalid_o;
  assign data_stall_o  = data_req_i & ~data_rvalid_o;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single-ported unified instruction/data memory between the fetch stage and the load/store stage of the pipelined core. It accepts at most one outstanding transaction and arbitrates with fixed data priority plus starvation protection for fetch. It also generates the stall signals that gate the PC register and pipeline enables, and discards fetch responses invalidated by a branch/jump redirect. It sits between the fetch/memory stages and the memory model that replaces the separate instruction memory.

## Interface
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 bits)
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (≥1)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- fetch_req  in  1  fetch request; held with fetch_addr stable until fetch_rvalid or fetch_kill
- fetch_addr  in  AW  fetch byte address (PC)
- fetch_kill  in  1  redirect pulse (PCSrcE taken); invalidates current fetch
- fetch_rvalid  out  1  fetch response valid
- fetch_rdata  out  DW  fetched instruction
- fetch_stall  out  1  fetch_req & ~fetch_rvalid; drives PCWrite low and IF/ID hold
- data_req, data_we  in  1  data request / write
- data_be  in  DW/8  byte enables
- data_addr  in  AW; data_wdata  in  DW
- data_rvalid  out  1  data response (read data or write ack)
- data_rdata  out  DW
- data_stall  out  1  data_req & ~data_rvalid
- mem_req, mem_we  out  1; mem_be  out  DW/8; mem_addr  out  AW; mem_wdata  out  DW
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  response, earliest the cycle after gnt
- mem_rdata  in  DW

## Operation
- FSM: IDLE, REQ, RESP. Registers: state, owner (FETCH/DATA), killed flag, latched request fields, starve count.
- IDLE: if a request is pending, select an owner, latch its addr/we/be/wdata, and go to REQ. If no request is pending, stay in IDLE.
- Owner selection in IDLE:
  - Only data_req: data.
  - Only fetch_req: fetch.
  - Both: data, unless starve count == STARVE_MAX, then fetch.
- Fetch is never a write: mem_we=0, mem_be=all ones.
- REQ: mem_req=1 with latched fields; stay until mem_gnt; on mem_gnt go to RESP.
- mem_req is never withdrawn before gnt, including on kill.
- RESP: wait for mem_rvalid.
  - Owner's rvalid = mem_rvalid and rdata = mem_rdata, combinationally in the same cycle.
  - On mem_rvalid go to IDLE.
- Kill:
  - fetch_kill while owner=FETCH in REQ/RESP sets killed. The response still completes, but fetch_rvalid stays 0. Killed clears on return to IDLE.
  - fetch_kill in IDLE blocks fetch from arbitration that cycle. Data may still be accepted.
  - fetch_kill while owner=DATA has no effect.
- Starve count:
  - Increments (saturating at STARVE_MAX) on each data acceptance while fetch_req=1.
  - Clears on fetch acceptance or whenever fetch_req=0 in IDLE.
- rdata outputs are don't-care when rvalid=0. Non-owner rvalid is always 0.

## Timing
- Reset values:
  - state=IDLE, owner=FETCH, killed=0, starve=0.
  - All mem_* outputs 0; all rvalid 0.
  - stall outputs follow their combinational equations.
- Minimum transaction: accept at t, mem_req at t+1, gnt at t+1, mem_rvalid/owner rvalid at t+2, IDLE at t+3. Throughput is one transaction per 3 cycles; each extra gnt or rvalid wait adds 1 cycle.
- Requesters update req/addr in the cycle after rvalid. IDLE samples only those fresh values, so there is no double-issue.
- Simultaneous fetch_kill and mem_rvalid for a fetch: response is suppressed (fetch_rvalid=0).
- Simultaneous kill and new fetch_req in IDLE: fetch is ignored that cycle; the corrected PC is accepted at the next IDLE.
- Reset mid-transaction: immediate return to IDLE and in-flight response is lost. The memory model must be reset on the same rst.

## Structure
- Shared package: state enum (IDLE/REQ/RESP) and owner constants (OWN_FETCH, OWN_DATA).
- One sub-module: arb_starve_counter, a saturating counter with inc/clr inputs and an at_max output, parameterised by STARVE_MAX.

## Test plan
- Single fetch at fetch_addr=0x0000_0010, mem_gnt immediate, mem_rvalid next cycle with rdata=0x0000_0013 -> fetch_rvalid pulses at t+2 with 0x0000_0013; fetch_stall high at t..t+1, low at t+2.
- Data store (addr=0x100, wdata=0xDEADBEEF, be=4'b0011) concurrent with fetch -> data granted first with mem_we=1 and mem_be=0011; fetch issued after data_rvalid.
- data_req held continuously alongside fetch_req with STARVE_MAX=4 -> exactly 4 data grants, then a fetch grant, then count restarts.
- fetch_kill during REQ with mem_gnt delayed 3 cycles -> mem_req stays high until gnt; response arrives but fetch_rvalid stays 0; next fetch of new PC 0x40 proceeds normally.
- fetch_kill coincident with mem_rvalid -> fetch_rvalid=0; FSM returns to IDLE next cycle.
- rst asserted in RESP -> all mem_* and rvalid outputs 0 immediately; after release, a fetch to 0x0 completes normally.
